// File: rtl/fc_port_state.sv
// fc_port_state: FC-1 port state machine for a single Fibre Channel link.
// Consumes one decoded ordered-set code per clock, recognises primitive
// sequences (three consecutive identical valid words), tracks the port
// state and selects the fill / primitive sequence the transmitter sends.
module fc_port_state #(
    parameter int RTTOV_CYCLES = 10_000_000,
    parameter int LOS_CYCLES   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_prim_valid,
    input  logic [4:0]  rx_prim,
    input  logic        rx_sync,
    input  logic        lr_req,
    input  logic        offline,
    output logic [3:0]  state,
    output logic [4:0]  tx_prim,
    output logic        active,
    output logic [15:0] link_up_count
);

    localparam int LOS_W = $clog2(LOS_CYCLES + 1);
    localparam int TMR_W = $clog2(RTTOV_CYCLES + 1);

    typedef enum logic [3:0] {
        ST_ACTIVE = 4'd0,
        ST_LR1    = 4'd1,
        ST_LR2    = 4'd2,
        ST_LR3    = 4'd3,
        ST_LF1    = 4'd4,
        ST_LF2    = 4'd5,
        ST_OL1    = 4'd6,
        ST_OL2    = 4'd7,
        ST_OL3    = 4'd8
    } state_e;

    typedef enum logic [4:0] {
        P_IDLE = 5'd0,
        P_NOS  = 5'd23,
        P_OLS  = 5'd24,
        P_LR   = 5'd25,
        P_LRR  = 5'd26
    } prim_e;

    // Primitive the transmitter sends continuously while in a given state.
    function automatic prim_e tx_for(input state_e s);
        case (s)
            ST_ACTIVE: tx_for = P_IDLE;
            ST_LR1:    tx_for = P_LR;
            ST_LR2:    tx_for = P_LRR;
            ST_LR3:    tx_for = P_IDLE;
            ST_LF1:    tx_for = P_NOS;
            ST_LF2:    tx_for = P_OLS;
            ST_OL1:    tx_for = P_OLS;
            ST_OL2:    tx_for = P_LR;
            default:   tx_for = P_OLS;
        endcase
    endfunction

    // States in which the R_T_TOV handshake timer runs.
    function automatic logic is_timed(input state_e s);
        is_timed = (s == ST_LR1) || (s == ST_LR2) || (s == ST_LR3) ||
                   (s == ST_OL1) || (s == ST_OL2);
    endfunction

    logic [4:0]       run_code_q;
    logic [1:0]       run_cnt_q;
    logic [LOS_W-1:0] los_cnt_q;
    logic [TMR_W-1:0] timer_q;
    state_e           state_q;
    state_e           state_d;
    prim_e            tx_prim_q;
    logic             active_q;
    logic [15:0]      link_up_q;

    logic run_full;
    logic rec_idle, rec_nos, rec_ols, rec_lr, rec_lrr;
    logic los, tmo;

    assign run_full = (run_cnt_q == 2'd3);
    assign rec_idle = run_full && (run_code_q == P_IDLE);
    assign rec_nos  = run_full && (run_code_q == P_NOS);
    assign rec_ols  = run_full && (run_code_q == P_OLS);
    assign rec_lr   = run_full && (run_code_q == P_LR);
    assign rec_lrr  = run_full && (run_code_q == P_LRR);

    assign los = (los_cnt_q == LOS_W'(LOS_CYCLES));
    assign tmo = (timer_q == TMR_W'(RTTOV_CYCLES));

    // Run register: last valid code and how many times in a row it was seen.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // always_ff samples the pre-edge values of the others, exactly like
        // the flops they model; blocking here would create order races.
        if (reset) begin
            run_code_q <= '0;
            run_cnt_q  <= 2'd0;
        end else if (!rx_prim_valid || !rx_sync) begin
            run_cnt_q <= 2'd0;
        end else if (rx_prim == run_code_q) begin
            if (run_cnt_q != 2'd3) run_cnt_q <= run_cnt_q + 2'd1;
        end else begin
            run_code_q <= rx_prim;
            run_cnt_q  <= 2'd1;
        end
    end

    // Loss-of-sync counter: consecutive cycles with rx_sync low, saturating.
    always_ff @(posedge clk) begin
        if (reset || rx_sync) begin
            los_cnt_q <= '0;
        end else if (!los) begin
            los_cnt_q <= los_cnt_q + LOS_W'(1);
        end
    end

    // Next-state selection, strictly by event priority.
    always_comb begin
        // NOTE: default first so every path assigns state_d; a missing
        // assignment on some branch would otherwise infer a latch.
        state_d = state_q;
        if (offline) begin
            state_d = ST_OL3;
        end else if (state_q == ST_OL3) begin
            state_d = ST_OL1;
        end else if (los || tmo) begin
            state_d = ST_LF1;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (rec_lr)       state_d = ST_LR2;
                    else if (rec_lrr) state_d = ST_LR3;
                    else if (rec_ols) state_d = ST_OL2;
                    else if (rec_nos) state_d = ST_LF2;
                    else if (lr_req)  state_d = ST_LR1;
                end
                ST_LR1, ST_OL2: begin
                    if (rec_lr  && state_q != ST_LR1 || rec_lr && state_q == ST_LR1)
                                      state_d = ST_LR2;
                    else if (rec_lrr) state_d = ST_LR3;
                    else if (rec_ols && state_q == ST_LR1) state_d = ST_OL2;
                    else if (rec_nos) state_d = ST_LF2;
                end
                ST_LR2: begin
                    if (rec_idle)     state_d = ST_ACTIVE;
                    else if (rec_ols) state_d = ST_OL2;
                    else if (rec_nos) state_d = ST_LF2;
                end
                ST_LR3: begin
                    if (rec_idle)     state_d = ST_ACTIVE;
                    else if (rec_lr)  state_d = ST_LR2;
                    else if (rec_ols) state_d = ST_OL2;
                    else if (rec_nos) state_d = ST_LF2;
                end
                ST_LF1: begin
                    if (rec_ols)      state_d = ST_OL2;
                    else if (rec_nos) state_d = ST_LF2;
                end
                ST_LF2: begin
                    if (rec_ols)      state_d = ST_OL2;
                    else if (rec_lr)  state_d = ST_LR2;
                end
                ST_OL1: begin
                    if (rec_ols)      state_d = ST_OL2;
                    else if (rec_lr)  state_d = ST_LR2;
                    else if (rec_nos) state_d = ST_LF2;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Port FSM registers: state, registered outputs, timer and link-up count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_LF1;
            tx_prim_q <= P_NOS;
            active_q  <= 1'b0;
            timer_q   <= '0;
            link_up_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            tx_prim_q <= tx_for(state_d);
            active_q  <= (state_d == ST_ACTIVE);

            if ((state_d != state_q) || !is_timed(state_q)) begin
                timer_q <= '0;
            end else if (!tmo) begin
                timer_q <= timer_q + TMR_W'(1);
            end

            if ((state_d == ST_ACTIVE) && (state_q != ST_ACTIVE) &&
                (link_up_q != 16'hFFFF)) begin
                link_up_q <= link_up_q + 16'd1;
            end
        end
    end

    assign state         = state_q;
    assign tx_prim       = tx_prim_q;
    assign active        = active_q;
    assign link_up_count = link_up_q;

endmodule

// File: tb/tb_fc_port_state.sv
// tb_fc_port_state: directed scoreboard bench for fc_port_state.
// Stimulus pushes hand-computed expected outputs into a queue after each
// relevant edge; a monitor pops and compares them on the falling edge.
module tb_fc_port_state;

    localparam logic [3:0] S_ACTIVE = 4'd0;
    localparam logic [3:0] S_LR1    = 4'd1;
    localparam logic [3:0] S_LR2    = 4'd2;
    localparam logic [3:0] S_LR3    = 4'd3;
    localparam logic [3:0] S_LF1    = 4'd4;
    localparam logic [3:0] S_LF2    = 4'd5;
    localparam logic [3:0] S_OL1    = 4'd6;
    localparam logic [3:0] S_OL2    = 4'd7;
    localparam logic [3:0] S_OL3    = 4'd8;

    localparam logic [4:0] C_IDLE = 5'd0;
    localparam logic [4:0] C_NOS  = 5'd23;
    localparam logic [4:0] C_OLS  = 5'd24;
    localparam logic [4:0] C_LR   = 5'd25;
    localparam logic [4:0] C_LRR  = 5'd26;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_prim_valid;
    logic [4:0]  rx_prim;
    logic        rx_sync;
    logic        lr_req;
    logic        offline;
    logic [3:0]  state;
    logic [4:0]  tx_prim;
    logic        active;
    logic [15:0] link_up_count;

    typedef struct {
        string       name;
        logic [25:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    fc_port_state #(
        .RTTOV_CYCLES(100),
        .LOS_CYCLES  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_prim_valid(rx_prim_valid),
        .rx_prim      (rx_prim),
        .rx_sync      (rx_sync),
        .lr_req       (lr_req),
        .offline      (offline),
        .state        (state),
        .tx_prim      (tx_prim),
        .active       (active),
        .link_up_count(link_up_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [25:0] got, input logic [25:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got state=%0d tx=%0d active=%0b count=%0d, required state=%0d tx=%0d active=%0b count=%0d",
                     name, got[25:22], got[21:17], got[16], got[15:0],
                     exp[25:22], exp[21:17], exp[16], exp[15:0]);
        end
    endtask

    // Monitor: compare every pending expectation against the settled outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                check(e.name, {state, tx_prim, active, link_up_count}, e.exp);
            end
        end
    end

    task automatic expect_out(input string n, input logic [3:0] s, input logic [4:0] t,
                              input logic a, input logic [15:0] c);
        exp_t e;
        e.name = n;
        e.exp  = {s, t, a, c};
        q.push_back(e);
    endtask

    // One clock: drive the receive inputs, take the edge, settle 1 time unit.
    task automatic cyc(input logic v, input logic [4:0] p, input logic s);
        rx_prim_valid = v;
        rx_prim       = p;
        rx_sync       = s;
        @(posedge clk);
        #1;
    endtask

    // Three matching words followed by one data cycle; the FSM reacts on the last edge.
    task automatic seq(input logic [4:0] p);
        repeat (3) cyc(1'b1, p, 1'b1);
        cyc(1'b0, 5'd0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; rx_prim_valid = 1'b0; rx_prim = 5'd0; rx_sync = 1'b1;
        lr_req = 1'b0; offline = 1'b0;
        repeat (2) cyc(1'b0, 5'd0, 1'b1);
        expect_out("reset", S_LF1, C_NOS, 1'b0, 16'd0);
        reset = 1'b0;

        // 1: NOS run takes LF1 to LF2 one edge after the third word.
        repeat (3) cyc(1'b1, C_NOS, 1'b1);
        expect_out("t1_no_early", S_LF1, C_NOS, 1'b0, 16'd0);
        cyc(1'b0, 5'd0, 1'b1);
        expect_out("t1_lf2", S_LF2, C_OLS, 1'b0, 16'd0);

        // 2: OLS -> OL2, LRR -> LR3, IDLE -> ACTIVE.
        seq(C_OLS);
        expect_out("t2_ol2", S_OL2, C_LR, 1'b0, 16'd0);
        seq(C_LRR);
        expect_out("t2_lr3", S_LR3, C_IDLE, 1'b0, 16'd0);
        seq(C_IDLE);
        expect_out("t2_active", S_ACTIVE, C_IDLE, 1'b1, 16'd1);

        // 3: an interrupted LR run is not a sequence; three in a row is.
        cyc(1'b1, C_LR, 1'b1);
        cyc(1'b1, C_LR, 1'b1);
        cyc(1'b0, 5'd0, 1'b1);
        cyc(1'b1, C_LR, 1'b1);
        cyc(1'b1, C_LR, 1'b1);
        expect_out("t3_broken_run", S_ACTIVE, C_IDLE, 1'b1, 16'd1);
        cyc(1'b1, C_LR, 1'b1);
        expect_out("t3_rec_pending", S_ACTIVE, C_IDLE, 1'b1, 16'd1);
        cyc(1'b0, 5'd0, 1'b1);
        expect_out("t3_lr2", S_LR2, C_LRR, 1'b0, 16'd1);
        seq(C_IDLE);
        expect_out("t3_back_active", S_ACTIVE, C_IDLE, 1'b1, 16'd2);

        // 4: lr_req enters LR1 at once; R_T_TOV expiry goes to LF1 on edge 101.
        lr_req = 1'b1;
        cyc(1'b1, C_IDLE, 1'b1);
        lr_req = 1'b0;
        expect_out("t4_lr1", S_LR1, C_LR, 1'b0, 16'd2);
        repeat (100) cyc(1'b1, C_IDLE, 1'b1);
        expect_out("t4_before_tmo", S_LR1, C_LR, 1'b0, 16'd2);
        cyc(1'b1, C_IDLE, 1'b1);
        expect_out("t4_tmo_lf1", S_LF1, C_NOS, 1'b0, 16'd2);

        // 5: back to ACTIVE, then loss of sync and offline priority.
        seq(C_OLS);
        expect_out("t5_ol2", S_OL2, C_LR, 1'b0, 16'd2);
        seq(C_LRR);
        expect_out("t5_lr3", S_LR3, C_IDLE, 1'b0, 16'd2);
        seq(C_IDLE);
        expect_out("t5_active", S_ACTIVE, C_IDLE, 1'b1, 16'd3);
        repeat (3) cyc(1'b0, 5'd0, 1'b0);
        cyc(1'b0, 5'd0, 1'b1);
        expect_out("t5_short_drop", S_ACTIVE, C_IDLE, 1'b1, 16'd3);
        repeat (4) cyc(1'b0, 5'd0, 1'b0);
        expect_out("t5_los_pending", S_ACTIVE, C_IDLE, 1'b1, 16'd3);
        cyc(1'b0, 5'd0, 1'b0);
        expect_out("t5_los_lf1", S_LF1, C_NOS, 1'b0, 16'd3);
        offline = 1'b1;
        cyc(1'b0, 5'd0, 1'b0);
        expect_out("t5_offline_wins", S_OL3, C_OLS, 1'b0, 16'd3);
        offline = 1'b0;
        cyc(1'b0, 5'd0, 1'b1);
        expect_out("t5_ol1", S_OL1, C_OLS, 1'b0, 16'd3);

        // 6: reset in OL2 on the third LRR word discards the run.
        seq(C_OLS);
        expect_out("t6_ol2", S_OL2, C_LR, 1'b0, 16'd3);
        cyc(1'b1, C_LRR, 1'b1);
        cyc(1'b1, C_LRR, 1'b1);
        reset = 1'b1;
        cyc(1'b1, C_LRR, 1'b1);
        reset = 1'b0;
        expect_out("t6_reset", S_LF1, C_NOS, 1'b0, 16'd0);
        cyc(1'b1, C_LRR, 1'b1);
        expect_out("t6_no_rec", S_LF1, C_NOS, 1'b0, 16'd0);

        // lr_req outside ACTIVE is ignored.
        lr_req = 1'b1;
        cyc(1'b0, 5'd0, 1'b1);
        lr_req = 1'b0;
        cyc(1'b0, 5'd0, 1'b1);
        expect_out("lr_req_ignored", S_LF1, C_NOS, 1'b0, 16'd0);

        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations unchecked, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
